// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth-table sweep/evaluate block.
// Holds the FSM state encoding, the mode encodings and the LUT width helper.
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    SWEEP = 2'd2,
    DONE  = 2'd3
  } tt_state_e;

  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_SWEEP  = 1'b1;

  // Number of truth-table entries for an n-input function.
  function automatic int tt_width(input int n);
    return 2 ** n;
  endfunction

endpackage

// File: rtl/tt_lut_reg.sv
// Truth-table register: resets to LUT_INIT, loads wdata when we is high
// (the caller gates we to IDLE), and offers a combinational read of lut[idx].
module tt_lut_reg
  import tt_pkg::*;
#(
  parameter int N_IN = 3,
  parameter logic [tt_width(N_IN)-1:0] LUT_INIT = 8'h70
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      we,
  input  logic [tt_width(N_IN)-1:0] wdata,
  input  logic [N_IN-1:0]           idx,
  output logic                      rdata
);

  logic [tt_width(N_IN)-1:0] lut;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lut <= LUT_INIT;
    end else if (we) begin
      lut <= wdata;
    end
  end

  assign rdata = lut[idx];

endmodule

// File: rtl/tt_sweep_eval.sv
// LUT-programmable N_IN-input function: single evaluation or full sweep,
// streamed over valid/ready. Optional stall counter under TT_STALL_COUNT_EN.
module tt_sweep_eval
  import tt_pkg::*;
#(
  parameter int N_IN = 3,
  parameter logic [tt_width(N_IN)-1:0] LUT_INIT = 8'h70
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      mode,
  input  logic [N_IN-1:0]           in_vec,
  input  logic                      lut_we,
  input  logic [tt_width(N_IN)-1:0] lut_wdata,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_IN-1:0]           out_idx,
  output logic                      out_s,
  output logic [N_IN:0]             ones_cnt,
  output logic                      busy,
  output logic [1:0]                dbg_state,
  output logic                      done
`ifdef TT_STALL_COUNT_EN
  , output logic [15:0]             stall_cnt
`endif
);

  localparam logic [N_IN-1:0] IDX_LAST = '1;

  // Handshake: a result transfers on a rising edge where out_valid && out_ready.
  // While out_valid is high and out_ready low, out_idx/out_s hold and out_valid
  // stays high; out_valid is only ever cleared by a transfer or by reset.

  tt_state_e state;
  logic      lut_rd;
  logic      accept;
  logic      start_ok;

  assign accept   = out_valid && out_ready;
  assign start_ok = (state == IDLE) && start && !lut_we;

  tt_lut_reg #(
    .N_IN     (N_IN),
    .LUT_INIT (LUT_INIT)
  ) u_lut (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (lut_we && (state == IDLE)),
    .wdata (lut_wdata),
    .idx   (out_idx),
    .rdata (lut_rd)
  );

  // Gated so that out_s reads 0 whenever no result is being presented.
  assign out_s     = out_valid & lut_rd;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_idx   <= '0;
      ones_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start_ok) begin
            ones_cnt  <= '0;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            if (mode == MODE_SWEEP) begin
              out_idx <= '0;
              state   <= SWEEP;
            end else begin
              out_idx <= in_vec;
              state   <= EVAL;
            end
          end
        end
        EVAL: begin
          if (accept) begin
            ones_cnt  <= ones_cnt + {{N_IN{1'b0}}, out_s};
            out_valid <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        SWEEP: begin
          if (accept) begin
            ones_cnt <= ones_cnt + {{N_IN{1'b0}}, out_s};
            if (out_idx == IDX_LAST) begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              out_idx <= out_idx + 1'b1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

`ifdef TT_STALL_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (start_ok) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tt_sweep_eval.sv
// Directed bench for tt_sweep_eval (N_IN = 3, LUT_INIT = 8'h70).
// Build with +define+TT_STALL_COUNT_EN to also check stall_cnt.
module tb_tt_sweep_eval;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [2:0] in_vec = '0;
  logic       lut_we = 1'b0;
  logic [7:0] lut_wdata = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] out_idx;
  logic       out_s;
  logic [3:0] ones_cnt;
  logic       busy;
  logic [1:0] dbg_state;
  logic       done;
`ifdef TT_STALL_COUNT_EN
  logic [15:0] stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] lut_model = 8'h70;
  logic [3:0] exp_q[$];   // {idx, s} of each result still to be accepted

  tt_sweep_eval #(.N_IN(3), .LUT_INIT(8'h70)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .in_vec    (in_vec),
    .lut_we    (lut_we),
    .lut_wdata (lut_wdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_s     (out_s),
    .ones_cnt  (ones_cnt),
    .busy      (busy),
    .dbg_state (dbg_state),
    .done      (done)
`ifdef TT_STALL_COUNT_EN
    , .stall_cnt (stall_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic write_lut(input logic [7:0] v);
    lut_we = 1'b1;
    lut_wdata = v;
    cyc();
    lut_we = 1'b0;
    lut_model = v;
  endtask

  task automatic run_eval(input logic [2:0] v, input int stall);
    out_ready = 1'b0;
    mode = 1'b0;
    in_vec = v;
    start = 1'b1;
    cyc();
    start = 1'b0;
    in_vec = ~v;
    check("ev_valid", out_valid, 1);
    check("ev_idx", out_idx, v);
    check("ev_s", out_s, lut_model[v]);
    check("ev_busy", busy, 1);
    repeat (stall) cyc();
    check("ev_hold_idx", out_idx, v);
    check("ev_hold_valid", out_valid, 1);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check("ev_done", done, 1);
    check("ev_valid_off", out_valid, 0);
    check("ev_ones", ones_cnt, {3'b000, lut_model[v]});
    cyc();
    check("ev_done_pulse", done, 0);
    check("ev_idle", busy, 0);
  endtask

  // rmode 0: ready high; 1: ready pattern 1,0,0,1.
  // poke_kind 1: lut_we of 8'h00 at poke_idx; 2: start pulse at poke_idx.
  task automatic run_sweep(input int rmode, input int poke_idx, input int poke_kind,
                           input logic [3:0] exp_ones);
    int c = 0;
    int n_acc = 0;
    int stalls = 0;
    int dones = 0;
    bit held = 0;
    logic [2:0] hold_idx = '0;
    logic hold_s = 1'b0;
    logic [3:0] rpat = 4'b1001;
    logic [3:0] e;
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back({i[2:0], lut_model[i]});
    mode = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("sw_valid", out_valid, 1);
    check("sw_first_idx", out_idx, 0);
    while (dones == 0 && c < 200) begin
      if (held) begin
        check("sw_hold_idx", out_idx, hold_idx);
        check("sw_hold_s", out_s, hold_s);
        held = 0;
      end
      out_ready = (rmode == 0) ? 1'b1 : rpat[3 - (c % 4)];
      lut_we = 1'b0;
      start = 1'b0;
      if (out_valid && out_idx == poke_idx[2:0] && poke_kind == 1) begin
        lut_we = 1'b1;
        lut_wdata = 8'h00;
      end
      if (out_valid && out_idx == poke_idx[2:0] && poke_kind == 2) begin
        start = 1'b1;
        mode = 1'b0;
        in_vec = 3'd5;
      end
      if (out_valid) begin
        if (out_ready) begin
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sw_idx", out_idx, e[3:1]);
            check("sw_s", out_s, e[0]);
            n_acc++;
          end else begin
            check("sw_extra_result", out_idx, 4'hF);
          end
        end else begin
          stalls++;
          held = 1;
          hold_idx = out_idx;
          hold_s = out_s;
        end
      end
      cyc();
      c++;
      if (done) dones++;
    end
    lut_we = 1'b0;
    start = 1'b0;
    mode = 1'b1;
    out_ready = 1'b0;
    check("sw_done_seen", dones, 1);
    check("sw_accepts", n_acc, 8);
    check("sw_ones", ones_cnt, exp_ones);
    check("sw_busy_in_done", busy, 1);
    check("sw_valid_in_done", out_valid, 0);
    if (rmode == 0) check("sw_latency", c, 8);
`ifdef TT_STALL_COUNT_EN
    check("sw_stall_cnt", stall_cnt, stalls);
`endif
    cyc();
    check("sw_done_pulse", done, 0);
    check("sw_idle", busy, 0);
    check("sw_ones_hold", ones_cnt, exp_ones);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int guard;
    #12;
    check("rst_valid", out_valid, 0);
    check("rst_idx", out_idx, 0);
    check("rst_s", out_s, 0);
    check("rst_ones", ones_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    check("rst_state", dbg_state, 0);

    // default LUT sweep, ready high
    run_sweep(0, -1, 0, 4'd3);

    // single evaluations
    run_eval(3'b110, 2);
    run_eval(3'b111, 0);

    // sweep with ready toggling
    run_sweep(1, -1, 0, 4'd3);

    // all-ones LUT, plus a write attempted mid-sweep
    write_lut(8'hFF);
    run_sweep(0, 3, 1, 4'd8);
    run_sweep(0, -1, 0, 4'd8);

    // write and start in the same idle cycle: write wins
    lut_we = 1'b1;
    lut_wdata = 8'h70;
    mode = 1'b1;
    start = 1'b1;
    cyc();
    lut_we = 1'b0;
    start = 1'b0;
    lut_model = 8'h70;
    check("ws_no_busy", busy, 0);
    check("ws_no_valid", out_valid, 0);
    check("ws_state", dbg_state, 0);
    run_eval(3'b000, 0);
    run_eval(3'b100, 1);

    // start while busy is ignored
    run_sweep(0, 2, 2, 4'd3);

    // reset mid-sweep
    write_lut(8'hFF);
    out_ready = 1'b1;
    mode = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    guard = 0;
    while (out_idx != 3'd4 && guard < 20) begin
      cyc();
      guard++;
    end
    check("mr_pre_idx", out_idx, 4);
    rst_n = 1'b0;
    #1;
    check("mr_valid", out_valid, 0);
    check("mr_idx", out_idx, 0);
    check("mr_s", out_s, 0);
    check("mr_ones", ones_cnt, 0);
    check("mr_busy", busy, 0);
    check("mr_done", done, 0);
    cyc();
    cyc();
    rst_n = 1'b1;
    lut_model = 8'h70;
    cyc();
    run_sweep(0, -1, 0, 4'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
